// File: rtl/vscale_hasti_sram_slave.sv
// AHB-Lite (HASTI) SRAM slave: NWORDS x 32-bit memory, byte/half/word writes, ERROR on bad transfers.
// Latency: data phase completes one cycle after accept (+WAIT_CYCLES waits with HASTI_SRAM_WAIT_EN defined).
// Backpressure: hready low in wait states and in the first error cycle; no address phase is accepted then.
module vscale_hasti_sram_slave #(
    parameter int unsigned NWORDS      = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        hclk,
    input  logic        reset,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam int unsigned AW = $clog2(NWORDS);
    localparam int unsigned BW = AW + 2;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("WAIT_CYCLES must be in 0..15");
    end
    if ((1 << AW) != NWORDS) begin : g_depth_pow2
        $error("NWORDS must be a power of two");
    end

    typedef enum logic [1:0] {
        OKDATA = 2'd0,
        WAIT   = 2'd1,
        ERR1   = 2'd2,
        ERR2   = 2'd3
    } state_t;

    typedef struct packed {
        logic          vld;
        logic          write;
        logic [2:0]    size;
        logic [BW-1:0] addr;
    } dphase_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
        case (size)
            3'd0:    lane_mask = 4'b0001 << offs;
            3'd1:    lane_mask = offs[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    state_t      state_q, state_d;
    dphase_t     dp_q;
    logic [31:0] mem [NWORDS];

`ifdef HASTI_SRAM_WAIT_EN
    logic [3:0]  wait_cnt_q, wait_cnt_d;
`endif

    logic          accept;
    logic          addr_oob;
    logic          size_bad;
    logic          misalign;
    logic          bad_xfer;
    logic          good_accept;
    logic          wr_en;
    logic [3:0]    wr_mask;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    assign hready = (state_q == OKDATA) || (state_q == ERR2);
    assign hresp  = (state_q == ERR1)   || (state_q == ERR2);

    assign accept   = hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign addr_oob = (haddr >> BW) != 32'd0;
    assign size_bad = hsize > 3'd2;

    always_comb begin
        misalign = 1'b0;
        case (hsize)
            3'd1:    misalign = haddr[0];
            3'd2:    misalign = |haddr[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign bad_xfer    = addr_oob || size_bad || misalign;
    assign good_accept = accept && !bad_xfer;

    // A valid data phase seen in OKDATA is completing on this edge; reset suppresses the write.
    assign wr_en   = dp_q.vld && dp_q.write && (state_q == OKDATA) && !reset;
    assign wr_mask = lane_mask(dp_q.size, dp_q.addr[1:0]);
    assign wr_idx  = dp_q.addr[BW-1:2];
    assign rd_idx  = haddr[BW-1:2];

    // Read port with forwarding of the lanes being written on the same edge.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    rd_word[8*i +: 8] = hwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef HASTI_SRAM_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            OKDATA, ERR2: begin
                state_d = OKDATA;
                if (accept) begin
                    if (bad_xfer) begin
                        state_d = ERR1;
                    end
`ifdef HASTI_SRAM_WAIT_EN
                    else if (WAIT_CYCLES != 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = 4'(WAIT_CYCLES - 1);
                    end
`endif
                    else begin
                        state_d = OKDATA;
                    end
                end
            end
            WAIT: begin
`ifdef HASTI_SRAM_WAIT_EN
                if (wait_cnt_q == 4'd0) begin
                    state_d = OKDATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
`else
                state_d = OKDATA;
`endif
            end
            ERR1:    state_d = ERR2;
            default: state_d = OKDATA;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            state_q <= OKDATA;
            dp_q    <= '0;
            hrdata  <= '0;
`ifdef HASTI_SRAM_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef HASTI_SRAM_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
            // Data-phase registers only move when the previous data phase completes.
            if (hready) begin
                dp_q.vld   <= good_accept;
                dp_q.write <= hwrite;
                dp_q.size  <= hsize;
                dp_q.addr  <= haddr[BW-1:0];
                if (good_accept) begin
                    hrdata <= rd_word;
                end
            end
        end
    end

endmodule

// File: doc/vscale_hasti_sram_slave.md
VSCALE_HASTI_SRAM_SLAVE -- requirements
Module: vscale_hasti_sram_slave

Interface
REQ-001 SHALL have parameter NWORDS, default 1024, memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, data-phase wait states per transfer (0..15); used only under HASTI_SRAM_WAIT_EN.
REQ-003 SHALL have port hclk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port haddr  input  32  byte address, address phase.
REQ-006 SHALL have port hwrite  input  1  1=write, address phase.
REQ-007 SHALL have port hsize  input  3  0=byte, 1=half, 2=word.
REQ-008 SHALL have port htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 SHALL have port hwdata  input  32  write data, data phase.
REQ-010 SHALL have port hrdata  output  32  read data, data phase.
REQ-011 SHALL have port hready  output  1  1=data phase completes this cycle.
REQ-012 SHALL have port hresp  output  1  0=OKAY, 1=ERROR.
REQ-013 SHALL ignore hburst, hprot, hmastlock; those ports are absent.

Function
REQ-014 SHALL accept an address phase when hready=1 and htrans is NONSEQ or SEQ; capture haddr, hwrite, hsize into data-phase registers.
REQ-015 SHALL treat IDLE/BUSY address phases as no access: next cycle hready=1, hresp=0, no memory change.
REQ-016 SHALL classify a transfer as bad when haddr >= 4*NWORDS, hsize > 2, or haddr not aligned to hsize (half: addr[0]=1; word: addr[1:0]!=0).
REQ-017 SHALL use states OKDATA, WAIT, ERR1, ERR2; OKDATA is the idle/complete state.
REQ-018 SHALL on bad accept go to ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then OKDATA; no memory write.
REQ-019 SHALL on good accept with zero wait states complete the data phase in the next cycle (hready=1, hresp=0).
REQ-020 SHALL read the memory word at haddr[log2(4*NWORDS)-1:2] on the accepting edge, so hrdata is valid during the entire data phase and held until the next accept.
REQ-021 SHALL write hwdata on the completing data-phase edge with byte lanes: byte -> lane haddr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four.
REQ-022 SHALL forward write data when a read address phase is accepted in the same cycle a write completes to the same word: the written lanes come from hwdata, the others from memory.
REQ-023 SHALL present hrdata unshifted (full word, slave does no lane extraction).
REQ-024 SHALL not accept an address phase while hready=0; haddr/htrans are ignored in those cycles.

Reset
REQ-025 SHALL on reset force state OKDATA, hready=1, hresp=0, hrdata=0, wait counter=0, discard any pending data phase without writing.
REQ-026 SHALL not clear memory contents on reset.
REQ-027 SHALL make reset dominate any accept or write in the same cycle.

Configuration
REQ-028 SHALL with HASTI_SRAM_WAIT_EN defined enter WAIT after a good accept for WAIT_CYCLES cycles with hready=0, hresp=0, then complete in OKDATA; WAIT_CYCLES=0 behaves as zero-wait.
REQ-029 SHALL with HASTI_SRAM_WAIT_EN undefined omit the wait counter; WAIT is unreachable, all good transfers are zero-wait.
REQ-030 SHALL keep error timing (REQ-018) identical regardless of HASTI_SRAM_WAIT_EN.

Verification
REQ-031 SHALL cover: word write 0xDEADBEEF to 0x10, then read 0x10 -> hrdata=0xDEADBEEF, hresp=0, hready=1 each data phase.
REQ-032 SHALL cover: byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-033 SHALL cover: write 0x55667788 to 0x20 back-to-back with read of 0x20 (no idle) -> read returns 0x55667788 via forwarding.
REQ-034 SHALL cover: read at 0x1002 with hsize=2 -> ERR1 (hready=0,hresp=1), ERR2 (hready=1,hresp=1); write at 4*NWORDS -> same, memory unchanged.
REQ-035 SHALL cover: HASTI_SRAM_WAIT_EN, WAIT_CYCLES=2, read -> exactly 2 cycles hready=0 then hready=1 with correct data; macro undefined -> 0 wait cycles.
REQ-036 SHALL cover: reset asserted during WAIT of a pending write -> next cycle hready=1, hresp=0, hrdata=0, target word unchanged.
